// File: rtl/rr_mux2_arbiter_pkg.sv
// Shared types and defaults for the two-requester round-robin mux arbiter.
package rr_mux2_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_G0   = 2'b01,
        ST_G1   = 2'b10
    } arb_state_e;

    localparam int DEFAULT_HOLD_MAX = 8;
    localparam int DEFAULT_CNT_W    = 4;

    function automatic logic is_grant(input arb_state_e st);
        return (st == ST_G0) || (st == ST_G1);
    endfunction

endpackage

// File: rtl/rr_mux2_arbiter_hold_cnt.sv
// Saturating ownership counter: clears on grant entry, counts while held, stops at HOLD_MAX-1.
module rr_mux2_arbiter_hold_cnt #(
    parameter int HOLD_MAX = 8,
    parameter int CNT_W    = 4
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clr,
    input  logic en,
    output logic at_max
);

    localparam logic [CNT_W-1:0] MAX_C = CNT_W'(HOLD_MAX - 1);

    logic [CNT_W-1:0] cnt_r;

    // Hold counter register with clear priority over increment
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (clr) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (en && (cnt_r != MAX_C)) begin
            cnt_r <= cnt_r + CNT_W'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign at_max = (cnt_r == MAX_C);

endmodule

// File: rtl/rr_mux2_arbiter.sv
// Round-robin arbiter for a shared 2:1 mux; registered grants and mux select.
module rr_mux2_arbiter
    import rr_mux2_arbiter_pkg::*;
#(
    parameter int HOLD_MAX = DEFAULT_HOLD_MAX,
    parameter int CNT_W    = DEFAULT_CNT_W
) (
    input  logic clk,
    input  logic reset_n,
    input  logic req0,
    input  logic req1,
    output logic gnt0,
    output logic gnt1,
    output logic sel,
    output logic busy
);

    arb_state_e state_r;
    arb_state_e next_s;
    logic       last_r;
    logic       gnt0_r;
    logic       gnt1_r;
    logic       sel_r;
    logic       busy_r;
    logic       at_max_s;
    logic       hold_s;

    // Next-state selection; forced hand-over only when the other side waits at the hold limit
    always_comb begin
        next_s = ST_IDLE;
        case (state_r)
            ST_IDLE: begin
                if (req0 && req1) begin
                    next_s = last_r ? ST_G0 : ST_G1;
                end else if (req0) begin
                    next_s = ST_G0;
                end else if (req1) begin
                    next_s = ST_G1;
                end else begin
                    next_s = ST_IDLE;
                end
            end
            ST_G0: begin
                if (!req0) begin
                    next_s = req1 ? ST_G1 : ST_IDLE;
                end else if (req1 && at_max_s) begin
                    next_s = ST_G1;
                end else begin
                    next_s = ST_G0;
                end
            end
            ST_G1: begin
                if (!req1) begin
                    next_s = req0 ? ST_G0 : ST_IDLE;
                end else if (req0 && at_max_s) begin
                    next_s = ST_G0;
                end else begin
                    next_s = ST_G1;
                end
            end
            default: begin
                next_s = ST_IDLE;
            end
        endcase
    end

    assign hold_s = (next_s == state_r) && is_grant(next_s);

    rr_mux2_arbiter_hold_cnt #(
        .HOLD_MAX (HOLD_MAX),
        .CNT_W    (CNT_W)
    ) u_hold_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (!hold_s),
        .en      (hold_s),
        .at_max  (at_max_s)
    );

    // State register with grants, select and last-owner registered on the same edge
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= ST_IDLE;
            gnt0_r  <= 1'b0;
            gnt1_r  <= 1'b0;
            sel_r   <= 1'b0;
            busy_r  <= 1'b0;
            last_r  <= 1'b1;
        end else begin
            state_r <= next_s;
            gnt0_r  <= (next_s == ST_G0);
            gnt1_r  <= (next_s == ST_G1);
            busy_r  <= is_grant(next_s);
            if (next_s == ST_G0) begin
                sel_r  <= 1'b0;
                last_r <= 1'b0;
            end else if (next_s == ST_G1) begin
                sel_r  <= 1'b1;
                last_r <= 1'b1;
            end else begin
                sel_r  <= sel_r;
                last_r <= last_r;
            end
        end
    end

    assign gnt0 = gnt0_r;
    assign gnt1 = gnt1_r;
    assign sel  = sel_r;
    assign busy = busy_r;

endmodule

// File: tb/tb_rr_mux2_arbiter.sv
// Scoreboard bench for rr_mux2_arbiter: directed request vectors with hand-computed grant sequences.
module tb_rr_mux2_arbiter;

    logic clk;
    logic reset_n;
    logic req0;
    logic req1;
    logic gnt0;
    logic gnt1;
    logic sel;
    logic busy;

    int checks;
    int failures;

    typedef struct {
        logic [3:0] val;
        string      tag;
    } exp_t;

    exp_t exp_q[$];

    rr_mux2_arbiter #(.HOLD_MAX(8), .CNT_W(4)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .req0    (req0),
        .req1    (req1),
        .gnt0    (gnt0),
        .gnt1    (gnt1),
        .sel     (sel),
        .busy    (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected value {gnt0,gnt1,sel}; busy is derived as gnt0|gnt1.
    task automatic push_exp(input logic [2:0] e, input string tag);
        exp_t x;
        x.val = {e, e[2] | e[1]};
        x.tag = tag;
        exp_q.push_back(x);
    endtask

    task automatic step(input logic r0, input logic r1, input logic [2:0] e, input string tag);
        @(negedge clk);
        req0 = r0;
        req1 = r1;
        push_exp(e, tag);
    endtask

    task automatic check_now(input string tag, input logic [3:0] act, input logic [3:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got g0g1 sel busy=%b expected %b", tag, act, req);
        end
    endtask

    // Monitor: compares every post-edge output against the oldest queued expectation
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                exp_t e;
                e = exp_q.pop_front();
                checks++;
                if (({gnt0, gnt1, sel, busy} !== e.val) || (gnt0 && gnt1)) begin
                    failures++;
                    $display("FAIL %s: got g0g1 sel busy=%b expected %b", e.tag, {gnt0, gnt1, sel, busy}, e.val);
                end
            end
        end
    end

    initial begin
        checks   = 0;
        failures = 0;
        reset_n  = 1'b0;
        req0     = 1'b1;
        req1     = 1'b1;

        // Reset held with both requesting
        repeat (3) @(posedge clk);
        #2;
        check_now("reset_outputs", {gnt0, gnt1, sel, busy}, 4'b0000);

        // Release reset: tie with last=1 goes to requester 0 for 8 cycles
        @(negedge clk);
        reset_n = 1'b1;
        push_exp(3'b100, "tie_g0_first");
        for (int i = 0; i < 7; i++) step(1'b1, 1'b1, 3'b100, "tie_g0");
        for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 3'b011, "tie_g1");
        for (int i = 0; i < 2; i++) step(1'b1, 1'b1, 3'b100, "tie_g0_again");

        // Seamless hand-over, then idle keeps sel=1
        step(1'b0, 1'b1, 3'b011, "handover_g1");
        step(1'b0, 1'b0, 3'b001, "idle_sel_hold1");

        // Single requester 1 for 3 cycles
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 3'b011, "single_req1");
        step(1'b0, 1'b0, 3'b001, "single_idle");
        step(1'b0, 1'b0, 3'b001, "single_idle2");

        // Tie from IDLE after requester 0 owned last -> requester 1 wins
        step(1'b1, 1'b0, 3'b100, "single_req0");
        step(1'b0, 1'b0, 3'b000, "idle_sel_hold0");
        step(1'b1, 1'b1, 3'b011, "tie_last0_g1");
        step(1'b1, 1'b1, 3'b011, "tie_last0_hold");
        step(1'b0, 1'b0, 3'b001, "idle_after_tie");

        // Saturation: long solo ownership must not wrap the hold counter
        for (int i = 0; i < 20; i++) step(1'b1, 1'b0, 3'b100, "sat_g0");
        step(1'b1, 1'b1, 3'b011, "sat_forced_g1");
        step(1'b1, 1'b1, 3'b011, "sat_g1_hold");

        // Reach G1 with cnt=5, then reset between edges
        step(1'b0, 1'b0, 3'b001, "pre_midreset_idle");
        for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 3'b011, "midreset_g1");
        @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        check_now("midreset_async_drop", {gnt0, gnt1, sel, busy}, 4'b0000);
        req0 = 1'b1;
        req1 = 1'b1;
        #1;
        reset_n = 1'b1;
        step(1'b1, 1'b1, 3'b100, "post_reset_tie_g0");
        step(1'b1, 1'b1, 3'b100, "post_reset_g0_hold");

        // Drain the scoreboard with a bounded wait
        for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge clk);
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
